// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply / divide unit.
//
// Performs one shift-add multiply step or one restoring divide step per clock.
// Signed operations are computed on operand magnitudes and sign-corrected in a
// final fix-up cycle. The result is published on HI/LO with a one-cycle done
// pulse.
//
// Parameters
//   WIDTH  operand / result width (even, 8..64)
//   CNTW   iteration counter width
// Ports
//   CLK    clock, rising edge
//   RST    asynchronous active-high reset
//   start  request an operation (accepted only when idle)
//   op     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A      multiplicand / dividend
//   B      multiplier / divisor
//   busy   operation in progress
//   done   one-cycle completion pulse
//   HI     upper product half / remainder
//   LO     lower product half / quotient
//   dbz    last completed division had a zero divisor
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             dbz
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  state_e            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic              is_div_q;
  logic              neg_res_q;  // negate product / quotient
  logic              neg_rem_q;  // negate remainder (dividend was negative)
  // Operand magnitude: multiplicand for MULT*, divisor for DIV*. One extra bit
  // so the most-negative value has a representable magnitude.
  logic [WIDTH:0]    opd_q;
  logic [WIDTH-1:0]  work_hi_q;  // partial product high half / partial remainder
  logic [WIDTH-1:0]  work_lo_q;  // multiplier shifting out / quotient shifting in

  // Accept-time decode
  logic              op_signed;
  logic              op_div;
  logic              div_by_zero;
  logic [WIDTH:0]    a_ext;
  logic [WIDTH:0]    b_ext;
  logic [WIDTH:0]    mag_a;
  logic [WIDTH:0]    mag_b;

  // Iteration step
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH-1:0]  div_diff;
  logic [WIDTH-1:0]  step_hi;
  logic [WIDTH-1:0]  step_lo;

  // Sign fix-up
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    op_signed   = ~op[0];
    op_div      = op[1];
    div_by_zero = op_div && (B == '0);
    a_ext       = op_signed ? {A[WIDTH-1], A} : {1'b0, A};
    b_ext       = op_signed ? {B[WIDTH-1], B} : {1'b0, B};
    mag_a       = a_ext[WIDTH] ? (~a_ext + 1'b1) : a_ext;
    mag_b       = b_ext[WIDTH] ? (~b_ext + 1'b1) : b_ext;
  end

  always_comb begin
    // Multiply: add multiplicand when the current multiplier LSB is set, then
    // shift the {carry, hi, lo} chain right by one.
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? opd_q : '0);
    // Divide: shift the next dividend bit into the partial remainder and try
    // to subtract the divisor; keep the difference only if it is non-negative.
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - opd_q[WIDTH-1:0];
    if (is_div_q) begin
      if (div_shift >= opd_q) begin
        step_hi = div_diff;
        step_lo = {work_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {work_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_raw = {work_hi_q, work_lo_q};
    prod_fix = neg_res_q ? (~prod_raw + 1'b1) : prod_raw;
    if (is_div_q) begin
      // Remainder follows the dividend's sign, so the quotient truncates
      // toward zero.
      fix_hi = neg_rem_q ? (~work_hi_q + 1'b1) : work_hi_q;
      fix_lo = neg_res_q ? (~work_lo_q + 1'b1) : work_lo_q;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opd_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (div_by_zero) begin
              // No iterations needed: publish the defined result directly.
              HI      <= A;
              LO      <= '1;
              dbz     <= 1'b1;
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              is_div_q  <= op_div;
              neg_res_q <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_rem_q <= op_signed && op_div && A[WIDTH-1];
              opd_q     <= op_div ? mag_b : mag_a;
              work_hi_q <= '0;
              work_lo_q <= op_div ? mag_a[WIDTH-1:0] : mag_b[WIDTH-1:0];
              cnt_q     <= '0;
              busy      <= 1'b1;
              state_q   <= StCalc;
            end
          end
        end
        StCalc: begin
          work_hi_q <= step_hi;
          work_lo_q <= step_lo;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == CNTW'(WIDTH - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          HI      <= fix_hi;
          LO      <= fix_lo;
          dbz     <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv at WIDTH=32: directed corner cases plus
// random operations checked against plain-arithmetic reference results.
module tb_alu_muldiv;

  localparam int W = 32;

  logic         CLK;
  logic         RST;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic         dbz;

  int vectors;
  int miscompares;

  alu_muldiv #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO),
    .dbz   (dbz)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results from ordinary 64-bit arithmetic.
  task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo,
                       output logic z, output int lat);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0]        ua, ub, up;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    z   = 1'b0;
    lat = W + 2;
    case (o)
      2'b00: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      2'b01: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      default: begin
        if (b == 0) begin
          hi = a; lo = '1; z = 1'b1; lat = 1;
        end else if (o == 2'b10) begin
          sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0];
        end else begin
          up = ua / ub; hi = W'(ua % ub); lo = up[31:0];
        end
      end
    endcase
  endtask

  // Issue one operation, optionally re-pulsing start (with junk operands) on
  // cycles p1/p2, and check latency, result, flags and the single done pulse.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int p1, input int p2);
    logic [W-1:0] ehi, elo;
    logic         ez;
    int           elat;
    int           ndone, first;
    logic [W-1:0] ohi, olo;
    logic         oz, obusy, busy1;
    model(o, a, b, ehi, elo, ez, elat);
    ndone = 0; first = 0; ohi = '0; olo = '0; oz = 1'b0; obusy = 1'b1; busy1 = 1'b0;
    @(negedge CLK);
    start = 1'b1; op = o; A = a; B = b;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) busy1 = busy;
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = cyc; ohi = HI; olo = LO; oz = dbz; obusy = busy;
        end
      end
      // Operands change every cycle so any late sampling corrupts the result.
      op = 2'($urandom); A = $urandom; B = $urandom;
      start = (cyc == p1) || (cyc == p2);
    end
    check("latency", 64'(first), 64'(elat));
    check("done_pulses", 64'(ndone), 64'd1);
    check("HI", {32'b0, ohi}, {32'b0, ehi});
    check("LO", {32'b0, olo}, {32'b0, elo});
    check("dbz", {63'b0, oz}, {63'b0, ez});
    check("busy_at_done", {63'b0, obusy}, 64'd0);
    check("busy_cycle1", {63'b0, busy1}, {63'b0, elat > 1});
    check("busy_after", {63'b0, busy}, 64'd0);
    check("hold_HI_LO", {HI, LO}, {ehi, elo});
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    int           dpulse;
    vectors = 0; miscompares = 0;
    RST = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    #2 RST = 1'b1;
    #1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_HI_LO", {HI, LO}, 64'd0);
    check("rst_dbz", {63'b0, dbz}, 64'd0);
    // Start held during reset must not be accepted.
    start = 1'b1; op = 2'b01; A = 32'd9; B = 32'd9;
    repeat (3) @(negedge CLK);
    check("rst_priority_busy", {63'b0, busy}, 64'd0);
    start = 1'b0;
    RST = 1'b0;

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b11, 32'd100, 32'd0, 0, 0);
    run_op(2'b11, 32'd100, 32'd7, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'd0, 0, 0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op(2'b01, 32'd3, 32'd5, 5, 34);

    // Reset in the middle of a divide.
    @(negedge CLK);
    start = 1'b1; op = 2'b10; A = 32'd1000; B = 32'd3;
    dpulse = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge CLK);
      start = 1'b0;
      if (done) dpulse++;
    end
    RST = 1'b1;
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_HI_LO", {HI, LO}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge CLK);
      if (done) dpulse++;
    end
    check("abort_no_done", 64'(dpulse), 64'd0);
    run_op(2'b00, 32'd2, 32'd2, 0, 0);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = '1;
        2: rb = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op(ro, ra, rb, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
